// File: rtl/io_pkg.sv
// Shared definitions for the input responder slice.
//   state_t      : responder handshake state (IDLE, ACK)
//   SERVED_WIDTH : width of the completed-transfer counter
package io_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_t;

  localparam int unsigned SERVED_WIDTH = 8;

  // Width of a FIFO occupancy count able to hold the value DEPTH itself.
  function automatic int unsigned level_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/io_in_responder_if.sv
// Bus bundle for io_in_responder: host push port plus the CPU input handshake.
//   i_push / i_push_data      : host enqueues a word
//   o_full / o_level          : FIFO occupancy
//   o_overflow                : sticky dropped-push flag
//   i_status                  : CPU request
//   o_control / o_in          : acknowledge and presented word
//   o_served                  : completed transfer count
// Modports: master = host/CPU side, slave = responder.
interface io_in_responder_if
  import io_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 4
);

  localparam int unsigned LW = level_width(DEPTH);

  logic                    i_push;
  logic [DATA_WIDTH-1:0]   i_push_data;
  logic                    o_full;
  logic [LW-1:0]           o_level;
  logic                    o_overflow;
  logic                    i_status;
  logic                    o_control;
  logic [DATA_WIDTH-1:0]   o_in;
  logic [SERVED_WIDTH-1:0] o_served;

  modport master (
    output i_push, i_push_data, i_status,
    input  o_full, o_level, o_overflow, o_control, o_in, o_served
  );

  modport slave (
    input  i_push, i_push_data, i_status,
    output o_full, o_level, o_overflow, o_control, o_in, o_served
  );

endinterface

// File: rtl/io_fifo.sv
// Synchronous FIFO with wrap-around pointers carrying one extra bit so that
// full and empty are distinguished by pointer difference.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_push/i_push_data : enqueue (accepted when not full, or when popping)
//   i_pop        : dequeue head (ignored when empty)
//   o_head       : current head word
//   o_level      : words held; o_full / o_empty derived from it
module io_fifo
  import io_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 4
)(
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] o_head,
  output logic [level_width(DEPTH)-1:0] o_level,
  output logic                  o_full,
  output logic                  o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = level_width(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  pop_ok;
  logic                  push_ok;

  assign o_level = wr_ptr - rd_ptr;
  assign o_full  = (o_level == PW'(DEPTH));
  assign o_empty = (o_level == '0);
  assign o_head  = mem[rd_ptr[AW-1:0]];

  assign pop_ok  = i_pop && !o_empty;
  // A pop on the same edge frees a slot, so a push while full is still taken.
  assign push_ok = i_push && (!o_full || pop_ok);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= i_push_data;
  end

endmodule

// File: rtl/io_in_responder.sv
// Input-side peripheral answering the CPU four-phase input handshake
// (status up -> control up -> status down -> control down) from a queue of
// words preloaded through a push port.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   bus (slave)  : push port, occupancy/overflow, CPU status/control/in,
//                  served counter
module io_in_responder
  import io_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 4
)(
  input  logic             i_clk,
  input  logic             i_rst,
  io_in_responder_if.slave bus
);

  localparam int unsigned LW = level_width(DEPTH);

  state_t                  state;
  logic                    control;
  logic [DATA_WIDTH-1:0]   in_word;
  logic [SERVED_WIDTH-1:0] served;
  logic                    overflow;

  logic [DATA_WIDTH-1:0]   head;
  logic [LW-1:0]           level;
  logic                    full;
  logic                    empty;
  logic                    pop;

  // Release edge in ACK retires the presented word.
  assign pop = (state == ACK) && !bus.i_status;

  io_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (bus.i_push),
    .i_push_data (bus.i_push_data),
    .i_pop       (pop),
    .o_head      (head),
    .o_level     (level),
    .o_full      (full),
    .o_empty     (empty)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= IDLE;
      control <= 1'b0;
      in_word <= '0;
      served  <= '0;
    end else begin
      case (state)
        IDLE: begin
          control <= 1'b0;
          if (bus.i_status && !empty) begin
            state   <= ACK;
            control <= 1'b1;
            in_word <= head;
          end
        end
        ACK: begin
          control <= 1'b1;
          if (!bus.i_status) begin
            state   <= IDLE;
            control <= 1'b0;
            served  <= served + SERVED_WIDTH'(1);
          end
        end
        default: begin
          state   <= IDLE;
          control <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      overflow <= 1'b0;
    end else if (bus.i_push && full && !pop) begin
      overflow <= 1'b1;
    end
  end

  assign bus.o_control  = control;
  assign bus.o_in       = in_word;
  assign bus.o_served   = served;
  assign bus.o_overflow = overflow;
  assign bus.o_level    = level;
  assign bus.o_full     = full;

endmodule

// File: tb/tb_io_in_responder.sv
module tb_io_in_responder;
  import io_pkg::*;

  localparam int unsigned DW = 16;
  localparam int unsigned DP = 4;

  logic clk;
  logic rst;

  io_in_responder_if #(.DATA_WIDTH(DW), .DEPTH(DP)) bus ();

  io_in_responder #(.DATA_WIDTH(DW), .DEPTH(DP)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [DW-1:0] exp_q[$];
  int unsigned   mdl_level;
  logic [7:0]    mdl_served;
  logic          mdl_ovf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    exp_q.delete();
    mdl_level  = 0;
    mdl_served = '0;
    mdl_ovf    = 1'b0;
  endtask

  task automatic push_word(input logic [DW-1:0] v);
    bus.i_push      = 1'b1;
    bus.i_push_data = v;
    tick();
    bus.i_push = 1'b0;
    if (mdl_level < DP) begin
      exp_q.push_back(v);
      mdl_level++;
    end else begin
      mdl_ovf = 1'b1;
    end
  endtask

  // Raise status and wait for the acknowledge; returns edges waited.
  task automatic acquire(output int unsigned cycles);
    logic [DW-1:0] exp;
    check("ctl_low_before_req", 32'(bus.o_control), 32'd0);
    bus.i_status = 1'b1;
    cycles = 0;
    while (cycles < 20) begin
      tick();
      cycles++;
      if (bus.o_control) break;
    end
    check("ack_seen", 32'(bus.o_control), 32'd1);
    if (exp_q.size() == 0) begin
      check("scoreboard_nonempty", 32'd0, 32'd1);
    end else begin
      exp = exp_q.pop_front();
      check("o_in", 32'(bus.o_in), 32'(exp));
    end
  endtask

  task automatic release_req();
    bus.i_status = 1'b0;
    tick();
    mdl_level--;
    mdl_served++;
    check("ctl_low_after_rel", 32'(bus.o_control), 32'd0);
    check("served", 32'(bus.o_served), 32'(mdl_served));
    check("level", 32'(bus.o_level), 32'(mdl_level));
  endtask

  task automatic transfer();
    int unsigned c;
    acquire(c);
    release_req();
  endtask

  initial begin
    int unsigned cyc;
    logic [DW-1:0] last;
    bus.i_push      = 1'b0;
    bus.i_push_data = '0;
    bus.i_status    = 1'b0;
    rst = 1'b1;
    model_reset();
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_control", 32'(bus.o_control), 32'd0);
    check("rst_in", 32'(bus.o_in), 32'd0);
    check("rst_level", 32'(bus.o_level), 32'd0);
    check("rst_full", 32'(bus.o_full), 32'd0);
    check("rst_ovf", 32'(bus.o_overflow), 32'd0);
    check("rst_served", 32'(bus.o_served), 32'd0);

    // Basic transfer
    push_word(16'd7);
    push_word(16'd8);
    check("basic_level2", 32'(bus.o_level), 32'd2);
    acquire(cyc);
    check("req_latency", cyc, 32'd1);
    release_req();
    transfer();
    check("basic_last_in", 32'(bus.o_in), 32'd8);
    tick();
    check("in_held", 32'(bus.o_in), 32'd8);

    // Empty request
    bus.i_status = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("empty_no_ack", 32'(bus.o_control), 32'd0);
    end
    bus.i_push      = 1'b1;
    bus.i_push_data = 16'd3;
    tick();
    bus.i_push = 1'b0;
    exp_q.push_back(16'd3);
    mdl_level++;
    check("push_ack_n", 32'(bus.o_control), 32'd0);
    tick();
    check("push_ack_n1", 32'(bus.o_control), 32'd1);
    check("push_ack_in", 32'(bus.o_in), 32'(exp_q.pop_front()));
    release_req();

    // Overflow
    for (int v = 1; v <= 5; v++) push_word(DW'(v));
    check("ovf_full", 32'(bus.o_full), 32'd1);
    check("ovf_flag", 32'(bus.o_overflow), 32'(mdl_ovf));
    check("ovf_level", 32'(bus.o_level), 32'd4);
    for (int i = 0; i < 4; i++) transfer();
    check("ovf_drained_full", 32'(bus.o_full), 32'd0);
    check("ovf_sticky", 32'(bus.o_overflow), 32'd1);

    // Reset mid-ACK
    push_word(16'h55);
    acquire(cyc);
    rst = 1'b1;
    #1;
    check("async_ctl_drop", 32'(bus.o_control), 32'd0);
    bus.i_status = 1'b0;
    model_reset();
    tick();
    rst = 1'b0;
    tick();
    check("mid_rst_level", 32'(bus.o_level), 32'd0);
    check("mid_rst_served", 32'(bus.o_served), 32'd0);
    check("mid_rst_in", 32'(bus.o_in), 32'd0);
    check("mid_rst_ovf", 32'(bus.o_overflow), 32'd0);

    // Simultaneous push/pop while full
    for (int v = 10; v <= 13; v++) push_word(DW'(v));
    check("sim_full", 32'(bus.o_full), 32'd1);
    acquire(cyc);
    bus.i_status    = 1'b0;
    bus.i_push      = 1'b1;
    bus.i_push_data = 16'd9;
    tick();
    bus.i_push = 1'b0;
    exp_q.push_back(16'd9);
    mdl_served++;
    check("sim_ovf", 32'(bus.o_overflow), 32'd0);
    check("sim_level", 32'(bus.o_level), 32'd4);
    check("sim_served", 32'(bus.o_served), 32'(mdl_served));
    for (int i = 0; i < 4; i++) transfer();
    check("sim_last_nine", 32'(bus.o_in), 32'd9);

    // Counter wrap
    last = '0;
    for (int i = 0; i < 256; i++) begin
      push_word(16'h00AA);
      transfer();
    end
    check("wrap_served", 32'(bus.o_served), 32'd5);
    check("wrap_in", 32'(bus.o_in), 32'h00AA);
    tick();
    check("wrap_ctl_idle", 32'(bus.o_control), 32'd0);
    check("wrap_level", 32'(bus.o_level), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
